register_bank8: RTL
===================

Name: register_bank8

Overview:
- Eight-entry general-purpose register bank for the multi-cycle datapath.
- Sits directly downstream of the 3-to-8 destination decoder and consumes its eight one-hot outputs as per-register write enables.
- Provides two read ports. Each read port latches into an A/B holding register every cycle, matching the multi-cycle register-read step.
- Flags malformed (non-one-hot) write-enable patterns instead of corrupting state.

Parameters:
- WIDTH, 32, data width of each register and of the write/read data buses.
- ZERO_R0, 0, when 1, register 0 is hard-wired to zero.
  - Writes to register 0 are discarded silently, with no error.
  - Reads of register 0 return 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  global write strobe from the controller (RegWrite).
- wen0..wen7  input  1 each  per-register write enables from the destination decoder; exactly one is high in normal use.
- wd  input  WIDTH  write-back data.
- ra1  input  3  read address, port 1.
- ra2  input  3  read address, port 2.
- rd1  output  WIDTH  registered read data, port 1 (A latch).
- rd2  output  WIDTH  registered read data, port 2 (B latch).
- err  output  1  sticky malformed-enable flag.
- err_clr  input  1  synchronous clear for err.

Behaviour:
- Reset:
  - While reset is high, asynchronously: all eight registers = 0, rd1 = 0, rd2 = 0, err = 0.
  - Reset asserted mid-write: no write occurs, reset wins.
  - First edge after deassertion behaves normally.
- Write qualification (combinational):
  - valid_wr = we AND popcount(wen7..wen0) == 1.
  - bad_wr = we AND popcount != 1, i.e. zero bits or two or more bits high.
  - we=0: wen bits are ignored entirely, with no write and no error.
- Write:
  - On a rising edge with valid_wr, reg[i] <= wd, where wen_i = 1.
  - No other register changes.
  - With ZERO_R0=1 and i=0, the write is discarded and no error is raised.
- Malformed enable:
  - On a rising edge with bad_wr, no register changes.
  - err <= 1 on that same edge, so it is visible the cycle after.
- Error clear:
  - err_clr on an edge sets err <= 0.
  - If bad_wr and err_clr coincide on the same edge, set wins: err stays 1.
- Read, latency 1 cycle:
  - Each rising edge, rd1 <= sel1 and rd2 <= sel2 unconditionally; no enable.
  - sel1 = wd if valid_wr and the write index == ra1; otherwise reg[ra1]. This is write-through bypass, so a same-cycle write is seen.
  - sel2 is defined the same way using ra2.
  - With ZERO_R0=1, sel for address 0 is always 0, including under bypass.
  - Both ports may address the same register; both return the identical value.
- No combinational path from any input to any output; all outputs are flops.
- Widths: wd is stored unmodified; there is no sign or zero extension inside the block.

Test Plan:
- Reset then read: assert reset mid-run with regs nonzero; ra1=3, ra2=5 -> rd1=0, rd2=0, err=0 immediately, before any clock edge.
- Single write then read:
  - Cycle 0: we=1, wen4 only, wd=0xDEADBEEF.
  - Next cycle: ra1=4 -> rd1=0xDEADBEEF one edge later.
  - All other registers read 0.
- Bypass:
  - Same cycle: we=1, wen2, wd=0x12345678, ra1=2, ra2=2 -> after that edge rd1=rd2=0x12345678.
  - Verify on the next cycle that reg2 holds 0x12345678.
- Malformed enables:
  - we=1 with wen1 and wen6 high, wd=0xFFFFFFFF -> reg1 and reg6 unchanged, err=1 after the edge.
  - A following we=1 with all wen=0 keeps err=1.
  - err_clr for one cycle -> err=0.
  - bad_wr and err_clr in the same cycle -> err=1.
- we gating: we=0 with wen7=1, wd=0xA5A5A5A5 -> reg7 unchanged, err=0.
- ZERO_R0=1 instance:
  - we=1, wen0, wd=0x55 -> no error; ra1=0 returns rd1=0, including the same-cycle bypass case.
  - Writes to reg1..reg7 behave normally.

Source files
------------

// File: rtl/register_bank8.sv
// Eight-entry register bank fed by one-hot decoder enables, with two
// registered read ports (write-through bypass) and a sticky malformed-enable flag.
module register_bank8 #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             wen0,
    input  logic             wen1,
    input  logic             wen2,
    input  logic             wen3,
    input  logic             wen4,
    input  logic             wen5,
    input  logic             wen6,
    input  logic             wen7,
    input  logic [WIDTH-1:0] wd,
    input  logic [2:0]       ra1,
    input  logic [2:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             err,
    input  logic             err_clr
);

    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    logic [NREG-1:0]  wen_c;
    logic             one_hot_c;
    logic             valid_wr_c;
    logic             bad_wr_c;
    logic [AW-1:0]    wr_idx_c;
    logic             wr_keep_c;
    logic [WIDTH-1:0] sel1_c;
    logic [WIDTH-1:0] sel2_c;
    logic [WIDTH-1:0] regs [NREG];

    assign wen_c = {wen7, wen6, wen5, wen4, wen3, wen2, wen1, wen0};

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign one_hot_c  = (wen_c != '0) && ((wen_c & (wen_c - NREG'(1))) == '0);
    assign valid_wr_c = we & one_hot_c;
    assign bad_wr_c   = we & ~one_hot_c;

    always_comb begin
        wr_idx_c = '0;
        for (int i = 0; i < NREG; i++) begin
            if (wen_c[i]) wr_idx_c = AW'(i);
        end
    end

    // A write to the hard-wired zero register is dropped without raising err.
    assign wr_keep_c = !(ZERO_R0 && (wr_idx_c == '0));

    // Read selection with same-cycle write-through; zero register overrides bypass.
    always_comb begin
        sel1_c = regs[ra1];
        if (valid_wr_c && (wr_idx_c == ra1)) sel1_c = wd;
        if (ZERO_R0 && (ra1 == '0)) sel1_c = '0;
        sel2_c = regs[ra2];
        if (valid_wr_c && (wr_idx_c == ra2)) sel2_c = wd;
        if (ZERO_R0 && (ra2 == '0)) sel2_c = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (valid_wr_c && wr_keep_c) begin
            regs[wr_idx_c] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= sel1_c;
            rd2 <= sel2_c;
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         err <= 1'b0;
        else if (bad_wr_c) err <= 1'b1;
        else if (err_clr)  err <= 1'b0;
    end

endmodule
